// File: rtl/rv32i_dmem_wb_responder_pkg.sv
// Shared Wishbone constants and parameter checks for the data-memory responder.
package rv32i_dmem_wb_responder_pkg;

    localparam int WB_DATA_W   = 32;
    localparam int WB_SEL_W    = 4;
    localparam int WB_LANES    = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    function automatic bit latency_legal(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/rv32i_dmem_wb_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module rv32i_bytewise_ram
    import rv32i_dmem_wb_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [WB_SEL_W-1:0]   we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WB_DATA_W-1:0]  wdata,
    output logic [WB_DATA_W-1:0]  rdata
);

    logic [WB_DATA_W-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];
    logic [WB_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int n = 0; n < WB_LANES; n++) begin
            if (we[n]) begin
                mem_q[addr][8*n +: 8] <= wdata[8*n +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rv32i_dmem_wb_responder.sv
// Pipelined Wishbone B4 responder for the core data port: byte-writable RAM,
// fixed ack latency and optional per-request back-pressure.
module rv32i_dmem_wb_responder
    import rv32i_dmem_wb_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int LATENCY      = 1,
    parameter int STALL_CYCLES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [31:0]          i_wb_addr,
    input  logic [WB_DATA_W-1:0] i_wb_data,
    input  logic [WB_SEL_W-1:0]  i_wb_sel,
    output logic                 o_wb_ack,
    output logic                 o_wb_stall,
    output logic [WB_DATA_W-1:0] o_wb_data
);

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("rv32i_dmem_wb_responder: LATENCY must be in 1..4");
    end

    localparam int CNT_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    logic                 accept;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stall_q, stall_d;
    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [LATENCY-1:0]   we_q, we_d;
    logic [WB_DATA_W-1:0] data_q, data_d;
    logic [WB_SEL_W-1:0]  ram_we;
    logic [WB_DATA_W-1:0] ram_rdata;
    logic [WB_DATA_W-1:0] rdata_last;
    logic                 rd_ack;
    logic                 unused_addr_bits;

    assign accept = i_wb_cyc & i_wb_stb & ~stall_q;
    assign ram_we = (accept & i_wb_we) ? i_wb_sel : '0;
    assign unused_addr_bits = ^{i_wb_addr[31:ADDR_WIDTH+2], i_wb_addr[1:0]};

    rv32i_bytewise_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we),
        .addr (i_wb_addr[ADDR_WIDTH+1:2]),
        .wdata(i_wb_data),
        .rdata(ram_rdata)
    );

    // Back-pressure: count down after every accept; dropping cyc abandons it.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_wb_cyc) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = CNT_W'(STALL_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        stall_d = (cnt_d != '0);
    end

    // Ack pipeline: stage 0 loads on accept, later stages shift unconditionally.
    always_comb begin
        vld_d    = '0;
        we_d     = '0;
        vld_d[0] = accept;
        we_d[0]  = i_wb_we;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            we_d[k]  = we_q[k-1];
        end
        if (!i_wb_cyc) begin
            vld_d = '0;
        end
    end

    // The RAM output register is the first data stage; extra stages follow it.
    if (LATENCY == 1) begin : g_rdata_direct
        assign rdata_last = ram_rdata;
    end else begin : g_rdata_pipe
        logic [LATENCY-2:0][WB_DATA_W-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d    = rdata_q;
            rdata_d[0] = ram_rdata;
            for (int k = 1; k < LATENCY - 1; k++) begin
                rdata_d[k] = rdata_q[k-1];
            end
        end

        always_ff @(posedge i_clk) begin
            rdata_q <= rdata_d;
        end

        assign rdata_last = rdata_q[LATENCY-2];
    end

    assign o_wb_ack   = vld_q[LATENCY-1] & i_wb_cyc;
    assign rd_ack     = o_wb_ack & ~we_q[LATENCY-1];
    assign o_wb_stall = stall_q;
    assign o_wb_data  = rd_ack ? rdata_last : data_q;

    always_comb begin
        data_d = data_q;
        if (rd_ack) begin
            data_d = rdata_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
            vld_q   <= '0;
            we_q    <= '0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            vld_q   <= vld_d;
            we_q    <= we_d;
            data_q  <= data_d;
        end
    end

endmodule
